// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - request, response and memory-command bundle for mem_port_arbiter
// Purpose: groups the fetch port, the load/store port, the shared-memory command and busy.
// Modports:
//   slave  - arbiter view: f_req/f_addr, d_req/d_we/d_addr/d_wdata/d_access and mem_dout in;
//            grants, done pulses, read data, mem_rd_en/mem_wr_en/mem_addr/mem_din/mem_access, busy out.
//   master - requesters plus memory view, the mirror image of slave.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32
);
    logic              f_req;
    logic [ADDR_W-1:0] f_addr;
    logic              f_grant;
    logic              f_done;
    logic [DATA_W-1:0] f_rdata;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [1:0]        d_access;
    logic              d_grant;
    logic              d_done;
    logic [DATA_W-1:0] d_rdata;

    logic              mem_rd_en;
    logic              mem_wr_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_din;
    logic [1:0]        mem_access;
    logic [DATA_W-1:0] mem_dout;

    logic              busy;

    modport slave (
        input  f_req, f_addr,
        output f_grant, f_done, f_rdata,
        input  d_req, d_we, d_addr, d_wdata, d_access,
        output d_grant, d_done, d_rdata,
        output mem_rd_en, mem_wr_en, mem_addr, mem_din, mem_access,
        input  mem_dout,
        output busy
    );

    modport master (
        output f_req, f_addr,
        input  f_grant, f_done, f_rdata,
        output d_req, d_we, d_addr, d_wdata, d_access,
        input  d_grant, d_done, d_rdata,
        input  mem_rd_en, mem_wr_en, mem_addr, mem_din, mem_access,
        output mem_dout,
        input  busy
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one single-port memory between instruction fetch and load/store
// Purpose: IDLE/ACCESS/RESP sequencer. A request seen in IDLE or RESP is arbitrated and its
//   command is driven to memory (with the winner's grant) in the following ACCESS cycle; the
//   next cycle (RESP) pulses the winner's done and presents read data.
// Ports:
//   i_clk  - system clock, rising edge
//   i_rst  - asynchronous active-low reset
//   io_bus - mem_port_arbiter_if.slave (requests, grants, done, read data, memory command, busy)
// Configuration macro: MEM_ARB_ROUND_ROBIN_EN
//   defined   - contested requests go to the port not granted last (fetch counts as last after reset)
//   undefined - data wins, except fetch wins once MAX_D_STREAK data grants were made while it waited
module mem_port_arbiter #(
    parameter int ADDR_W       = 9,
    parameter int DATA_W       = 32,
    parameter int MAX_D_STREAK = 4
) (
    input  logic              i_clk,
    input  logic              i_rst,
    mem_port_arbiter_if.slave io_bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t            r_state;
    logic              r_win_d;     // current access belongs to the data port
    logic              r_is_read;   // current access returns data (fetch or load)
    logic              r_busy;
    logic              r_f_grant;
    logic              r_d_grant;
    logic              r_f_done;
    logic              r_d_done;
    logic              r_mem_rd_en;
    logic              r_mem_wr_en;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_din;
    logic [1:0]        r_mem_access;
    logic [DATA_W-1:0] r_f_rdata;
    logic [DATA_W-1:0] r_d_rdata;

    logic              w_any_req;
    logic              w_pick_d;
    logic              w_f_resp;
    logic              w_d_load_resp;

    assign w_any_req = io_bus.f_req | io_bus.d_req;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic r_last_d;     // last grant went to the data port

    always_comb begin
        w_pick_d = io_bus.d_req;
        if (io_bus.d_req && io_bus.f_req) begin
            w_pick_d = ~r_last_d;
        end
    end
`else
    localparam logic [3:0] MAX_STREAK = 4'(MAX_D_STREAK);

    logic [3:0] r_streak;   // data grants made while fetch was waiting

    always_comb begin
        w_pick_d = io_bus.d_req;
        if (io_bus.f_req && (r_streak == MAX_STREAK)) begin
            w_pick_d = 1'b0;
        end
    end
`endif

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state      <= IDLE;
            r_win_d      <= 1'b0;
            r_is_read    <= 1'b0;
            r_busy       <= 1'b0;
            r_f_grant    <= 1'b0;
            r_d_grant    <= 1'b0;
            r_f_done     <= 1'b0;
            r_d_done     <= 1'b0;
            r_mem_rd_en  <= 1'b0;
            r_mem_wr_en  <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_din    <= '0;
            r_mem_access <= 2'b00;
            r_f_rdata    <= '0;
            r_d_rdata    <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            r_last_d     <= 1'b0;
`else
            r_streak     <= 4'd0;
`endif
        end else begin
            // Pulses and the memory command last exactly one cycle unless re-armed below.
            r_f_grant    <= 1'b0;
            r_d_grant    <= 1'b0;
            r_f_done     <= 1'b0;
            r_d_done     <= 1'b0;
            r_mem_rd_en  <= 1'b0;
            r_mem_wr_en  <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_din    <= '0;
            r_mem_access <= 2'b00;

            case (r_state)
                IDLE, RESP: begin
                    // mem_dout belongs to the access finishing now; keep it for the hold phase.
                    if (r_state == RESP && r_is_read) begin
                        if (r_win_d) begin
                            r_d_rdata <= io_bus.mem_dout;
                        end else begin
                            r_f_rdata <= io_bus.mem_dout;
                        end
                    end

                    if (w_any_req) begin
                        r_state   <= ACCESS;
                        r_busy    <= 1'b1;
                        r_win_d   <= w_pick_d;
                        r_f_grant <= ~w_pick_d;
                        r_d_grant <= w_pick_d;
                        if (w_pick_d) begin
                            r_is_read    <= ~io_bus.d_we;
                            r_mem_rd_en  <= ~io_bus.d_we;
                            r_mem_wr_en  <= io_bus.d_we;
                            r_mem_addr   <= io_bus.d_addr;
                            r_mem_din    <= io_bus.d_we ? io_bus.d_wdata : '0;
                            r_mem_access <= io_bus.d_access;
                        end else begin
                            r_is_read    <= 1'b1;
                            r_mem_rd_en  <= 1'b1;
                            r_mem_addr   <= io_bus.f_addr;
                        end
`ifdef MEM_ARB_ROUND_ROBIN_EN
                        r_last_d <= w_pick_d;
`else
                        if (!w_pick_d) begin
                            r_streak <= 4'd0;
                        end else if (io_bus.f_req && (r_streak != 4'hF)) begin
                            r_streak <= r_streak + 4'd1;
                        end
`endif
                    end else begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                end

                ACCESS: begin
                    r_state  <= RESP;
                    r_f_done <= ~r_win_d;
                    r_d_done <= r_win_d;
                end

                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Read data is live from memory during RESP so it is valid together with done,
    // then held from the register until the next read completes on that port.
    assign w_f_resp      = (r_state == RESP) && r_is_read && ~r_win_d;
    assign w_d_load_resp = (r_state == RESP) && r_is_read && r_win_d;

    assign io_bus.f_rdata    = w_f_resp      ? io_bus.mem_dout : r_f_rdata;
    assign io_bus.d_rdata    = w_d_load_resp ? io_bus.mem_dout : r_d_rdata;
    assign io_bus.f_grant    = r_f_grant;
    assign io_bus.d_grant    = r_d_grant;
    assign io_bus.f_done     = r_f_done;
    assign io_bus.d_done     = r_d_done;
    assign io_bus.mem_rd_en  = r_mem_rd_en;
    assign io_bus.mem_wr_en  = r_mem_wr_en;
    assign io_bus.mem_addr   = r_mem_addr;
    assign io_bus.mem_din    = r_mem_din;
    assign io_bus.mem_access = r_mem_access;
    assign io_bus.busy       = r_busy;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter against a transaction-level model
`timescale 1ns/1ps
module tb_mem_port_arbiter;
    localparam int ADDR_W       = 9;
    localparam int DATA_W       = 32;
    localparam int MAX_D_STREAK = 4;
    localparam int DEPTH        = 1 << ADDR_W;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   n_cmp  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mem_port_arbiter #(
        .ADDR_W       (ADDR_W),
        .DATA_W       (DATA_W),
        .MAX_D_STREAK (MAX_D_STREAK)
    ) dut (
        .i_clk  (clk),
        .i_rst  (rst_n),
        .io_bus (bus)
    );

    function automatic logic [31:0] init_word(input logic [8:0] a);
        if (a == 9'h010) return 32'hDEADBEEF;
        return ({23'd0, a} * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction

    // Synchronous single-port memory: read data appears the cycle after mem_rd_en.
    logic [31:0] mem_arr  [0:DEPTH-1];
    logic        mem_seen [0:DEPTH-1];
    always @(posedge clk) begin
        if (bus.mem_wr_en) begin
            mem_arr[bus.mem_addr]  <= bus.mem_din;
            mem_seen[bus.mem_addr] <= 1'b1;
        end
        if (bus.mem_rd_en)
            bus.mem_dout <= (mem_seen[bus.mem_addr] === 1'b1) ? mem_arr[bus.mem_addr] : init_word(bus.mem_addr);
    end

    // Reference model: each edge, an access granted last cycle moves to its response cycle;
    // if no command is on the bus right now and a request is present, a winner is chosen and
    // its command appears next cycle.
    logic [31:0] ref_mem  [0:DEPTH-1];
    logic        ref_seen [0:DEPTH-1];
    logic        m_g_valid, m_g_d, m_g_read, m_r_valid, m_r_d, m_last_d, m_pick_d;
    logic [8:0]  m_g_addr;
    logic [31:0] m_g_din, m_g_rdata, m_f_rdata, m_d_rdata;
    logic [1:0]  m_g_acc;
    int          m_streak;

    initial begin : ref_model
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_g_valid = 0; m_g_d = 0; m_g_read = 0; m_g_addr = 0; m_g_din = 0; m_g_acc = 0;
                m_g_rdata = 0; m_r_valid = 0; m_r_d = 0; m_f_rdata = 0; m_d_rdata = 0;
                m_streak = 0; m_last_d = 0;
            end else begin
                m_r_valid = m_g_valid;
                m_r_d     = m_g_d;
                if (m_g_valid && m_g_read) begin
                    if (m_g_d) m_d_rdata = m_g_rdata;
                    else       m_f_rdata = m_g_rdata;
                end
                if (!m_g_valid && (bus.f_req || bus.d_req)) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
                    m_pick_d = (bus.f_req && bus.d_req) ? !m_last_d : bus.d_req;
                    m_last_d = m_pick_d;
`else
                    m_pick_d = bus.d_req && !(bus.f_req && m_streak == MAX_D_STREAK);
                    if (!m_pick_d) m_streak = 0;
                    else if (bus.f_req && m_streak < 15) m_streak = m_streak + 1;
`endif
                    m_g_valid = 1;
                    m_g_d     = m_pick_d;
                    if (m_pick_d) begin
                        m_g_read = !bus.d_we;
                        m_g_addr = bus.d_addr;
                        m_g_acc  = bus.d_access;
                        m_g_din  = bus.d_we ? bus.d_wdata : 32'd0;
                    end else begin
                        m_g_read = 1;
                        m_g_addr = bus.f_addr;
                        m_g_acc  = 2'b00;
                        m_g_din  = 32'd0;
                    end
                    m_g_rdata = (ref_seen[m_g_addr] === 1'b1) ? ref_mem[m_g_addr] : init_word(m_g_addr);
                    if (m_pick_d && bus.d_we) begin
                        ref_mem[bus.d_addr]  = bus.d_wdata;
                        ref_seen[bus.d_addr] = 1'b1;
                    end
                end else begin
                    m_g_valid = 0; m_g_d = 0; m_g_read = 0; m_g_addr = 0; m_g_din = 0; m_g_acc = 0; m_g_rdata = 0;
                end
            end
        end
    end

    logic [113:0] act_vec, exp_vec;
    assign act_vec = {bus.f_grant, bus.d_grant, bus.mem_rd_en, bus.mem_wr_en, bus.mem_addr, bus.mem_din,
                      bus.mem_access, bus.f_done, bus.d_done, bus.f_rdata, bus.d_rdata, bus.busy};
    assign exp_vec = {m_g_valid & ~m_g_d, m_g_valid & m_g_d, m_g_valid & m_g_read, m_g_valid & ~m_g_read,
                      m_g_addr, m_g_din, m_g_acc, m_r_valid & ~m_r_d, m_r_valid & m_r_d,
                      m_f_rdata, m_d_rdata, m_g_valid | m_r_valid};

    task automatic test_reset;
        #1 rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++;
            if (act_vec !== 114'd0) begin
                n_fail++;
                $display("FAIL reset_outputs cyc %0d: got %h want 0", i, act_vec);
            end
        end
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_cmp++;
            if (act_vec !== exp_vec) begin
                n_fail++;
                $display("FAIL reset_idle cyc %0d: got %h want %h", i, act_vec, exp_vec);
            end
        end
    endtask

    task automatic test_single_fetch;
        @(negedge clk);
        bus.f_req = 1'b1; bus.f_addr = 9'h010;
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            n_cmp++;
            if (act_vec !== exp_vec) begin
                n_fail++;
                $display("FAIL single_fetch_model cyc %0d: got %h want %h", i, act_vec, exp_vec);
            end
            n_cmp++;
            if (i == 1) begin
                if ({bus.f_grant, bus.mem_rd_en, bus.mem_wr_en, bus.mem_addr} !== {1'b1, 1'b1, 1'b0, 9'h010}) begin
                    n_fail++;
                    $display("FAIL single_fetch_grant: got g=%b rd=%b wr=%b a=%h want 1 1 0 010",
                             bus.f_grant, bus.mem_rd_en, bus.mem_wr_en, bus.mem_addr);
                end
                bus.f_req = 1'b0;
            end else if (i == 2) begin
                if ({bus.f_done, bus.f_rdata} !== {1'b1, 32'hDEADBEEF}) begin
                    n_fail++;
                    $display("FAIL single_fetch_done: got done=%b rdata=%h want 1 deadbeef", bus.f_done, bus.f_rdata);
                end
            end else begin
                if ({bus.busy, bus.f_done, bus.f_rdata} !== {1'b0, 1'b0, 32'hDEADBEEF}) begin
                    n_fail++;
                    $display("FAIL single_fetch_idle: got busy=%b done=%b rdata=%h want 0 0 deadbeef",
                             bus.busy, bus.f_done, bus.f_rdata);
                end
            end
        end
    endtask

    task automatic test_store_load;
        @(negedge clk);
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 9'h020; bus.d_wdata = 32'h12345678; bus.d_access = 2'b00;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            n_cmp++;
            if (act_vec !== exp_vec) begin
                n_fail++;
                $display("FAIL store_load_model cyc %0d: got %h want %h", i, act_vec, exp_vec);
            end
            n_cmp++;
            case (i)
                1: begin
                    if ({bus.d_grant, bus.mem_wr_en, bus.mem_rd_en, bus.mem_addr, bus.mem_din, bus.mem_access}
                        !== {1'b1, 1'b1, 1'b0, 9'h020, 32'h12345678, 2'b00}) begin
                        n_fail++;
                        $display("FAIL store_cmd: got g=%b wr=%b rd=%b a=%h din=%h acc=%b want 1 1 0 020 12345678 00",
                                 bus.d_grant, bus.mem_wr_en, bus.mem_rd_en, bus.mem_addr, bus.mem_din, bus.mem_access);
                    end
                    bus.d_req = 1'b0;
                end
                2: begin
                    if ({bus.d_done, bus.d_grant} !== 2'b10) begin
                        n_fail++;
                        $display("FAIL store_done: got done=%b grant=%b want 1 0", bus.d_done, bus.d_grant);
                    end
                    bus.d_req = 1'b1; bus.d_we = 1'b0;
                end
                3: begin
                    if ({bus.d_grant, bus.mem_rd_en, bus.mem_wr_en, bus.mem_din} !== {1'b1, 1'b1, 1'b0, 32'd0}) begin
                        n_fail++;
                        $display("FAIL load_cmd: got g=%b rd=%b wr=%b din=%h want 1 1 0 0",
                                 bus.d_grant, bus.mem_rd_en, bus.mem_wr_en, bus.mem_din);
                    end
                    bus.d_req = 1'b0;
                end
                4: begin
                    if ({bus.d_done, bus.d_rdata} !== {1'b1, 32'h12345678}) begin
                        n_fail++;
                        $display("FAIL load_done: got done=%b rdata=%h want 1 12345678", bus.d_done, bus.d_rdata);
                    end
                end
                default: begin
                    if ({bus.busy, bus.d_rdata} !== {1'b0, 32'h12345678}) begin
                        n_fail++;
                        $display("FAIL load_hold: got busy=%b rdata=%h want 0 12345678", bus.busy, bus.d_rdata);
                    end
                end
            endcase
        end
    endtask

    task automatic test_simultaneous;
        logic [3:0] got, want;
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        bus.f_req = 1'b1; bus.f_addr = 9'h040;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 9'h050; bus.d_access = 2'b01;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            got  = {bus.d_grant, bus.d_done, bus.f_grant, bus.f_done};
            want = {i == 1, i == 2, i == 3, i == 4};
            n_cmp++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL simultaneous cyc %0d: got dg/dd/fg/fd=%b want %b", i, got, want);
            end
            n_cmp++;
            if (act_vec !== exp_vec) begin
                n_fail++;
                $display("FAIL simultaneous_model cyc %0d: got %h want %h", i, act_vec, exp_vec);
            end
            if (bus.d_grant) bus.d_req = 1'b0;
            if (bus.f_grant) bus.f_req = 1'b0;
        end
    endtask

    task automatic test_starvation;
        string seq, exp_seq;
        int    last_g;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        exp_seq = "dfdfdfdfdf";
`else
        exp_seq = "ddddfddddf";
`endif
        seq = ""; last_g = -1;
        @(negedge clk);
        bus.f_req = 1'b1; bus.f_addr = 9'h060;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 9'h070; bus.d_access = 2'b10;
        for (int c = 0; c < 40 && seq.len() < 10; c++) begin
            @(negedge clk);
            n_cmp++;
            if (act_vec !== exp_vec) begin
                n_fail++;
                $display("FAIL starvation_model cyc %0d: got %h want %h", c, act_vec, exp_vec);
            end
            if (bus.d_grant || bus.f_grant) begin
                if (last_g >= 0) begin
                    n_cmp++;
                    if (c - last_g != 2) begin
                        n_fail++;
                        $display("FAIL starvation_spacing: got %0d cycles want 2", c - last_g);
                    end
                end
                last_g = c;
                if (bus.d_grant) begin seq = {seq, "d"}; bus.d_addr = 9'($urandom_range(127)); end
                if (bus.f_grant) begin seq = {seq, "f"}; bus.f_addr = 9'($urandom_range(127)); end
            end
        end
        n_cmp++;
        if (seq != exp_seq) begin
            n_fail++;
            $display("FAIL starvation_order: got %s want %s", seq, exp_seq);
        end
        @(negedge clk);
        bus.f_req = 1'b0; bus.d_req = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset_mid_access;
        @(negedge clk);
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 9'h020; bus.d_access = 2'b00;
        @(negedge clk);
        n_cmp++;
        if ({bus.d_grant, bus.mem_rd_en} !== 2'b11) begin
            n_fail++;
            $display("FAIL midreset_grant: got g=%b rd=%b want 1 1", bus.d_grant, bus.mem_rd_en);
        end
        bus.d_req = 1'b0;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (act_vec !== 114'd0) begin
            n_fail++;
            $display("FAIL midreset_outputs: got %h want 0", act_vec);
        end
        @(negedge clk); rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({bus.d_done, bus.busy, bus.d_grant, bus.mem_rd_en} !== 4'b0000) begin
                n_fail++;
                $display("FAIL midreset_after cyc %0d: got done=%b busy=%b g=%b rd=%b want 0 0 0 0",
                         i, bus.d_done, bus.busy, bus.d_grant, bus.mem_rd_en);
            end
            n_cmp++;
            if (act_vec !== exp_vec) begin
                n_fail++;
                $display("FAIL midreset_model cyc %0d: got %h want %h", i, act_vec, exp_vec);
            end
        end
    endtask

    task automatic test_random(input int n_cyc);
        for (int c = 0; c < n_cyc + 4; c++) begin
            @(negedge clk);
            n_cmp++;
            if (act_vec !== exp_vec) begin
                n_fail++;
                $display("FAIL random cyc %0d: got %h want %h", c, act_vec, exp_vec);
            end
            if (bus.f_grant || !bus.f_req) begin
                if (c < n_cyc && $urandom_range(99) < 35) begin
                    bus.f_req = 1'b1; bus.f_addr = 9'($urandom_range(15));
                end else begin
                    bus.f_req = 1'b0;
                end
            end
            if (bus.d_grant || !bus.d_req) begin
                if (c < n_cyc && $urandom_range(99) < 45) begin
                    bus.d_req    = 1'b1;
                    bus.d_we     = 1'($urandom_range(1));
                    bus.d_addr   = 9'($urandom_range(15));
                    bus.d_wdata  = $urandom;
                    bus.d_access = 2'($urandom_range(2));
                end else begin
                    bus.d_req = 1'b0;
                end
            end
        end
    endtask

    initial begin
        bus.f_req = 1'b0; bus.f_addr = '0;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0; bus.d_access = 2'b00;
        test_reset;
        test_single_fetch;
        test_store_load;
        test_simultaneous;
        test_starvation;
        test_reset_mid_access;
        test_random(400);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
